// File: rtl/key_led_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : key_led_ctrl
//  Purpose  : Four debounced push-buttons select an LED pattern mode
//             (OFF / BLINK / RUN) and pause or resume the running pattern.
//  Revision : 1.0  initial release
// ============================================================================
module key_led_ctrl #(
    parameter int DELAY_10MS = 500_000,     // debounce hold time, sclk cycles
    parameter int STEP_CNT   = 25_000_000   // pattern step period, sclk cycles
) (
    input  logic       sclk,
    input  logic       s_rst_n,
    input  logic [3:0] key,
    output logic [3:0] led,
    output logic [1:0] mode,
    output logic       paused
);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_BLINK = 2'b01,
        MODE_RUN   = 2'b10
    } mode_t;

    localparam int                HOLD_W    = 19;
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(DELAY_10MS);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(DELAY_10MS - 1);
    localparam int                STEP_W    = (STEP_CNT > 1) ? $clog2(STEP_CNT) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CNT - 1);

    logic [3:0]        press;     // one-cycle debounced press pulses
    mode_t             state;
    logic [STEP_W-1:0] step;      // pattern step timer
    logic              running;   // step timer allowed to advance
    logic              tick;      // last cycle of a step period

    // ------------------------------------------------------------------------
    // Per-key debounce: the pulse fires on the cycle the counter would move
    // from DELAY_10MS-1 to DELAY_10MS, so exactly DELAY_10MS consecutive low
    // samples are needed and a saturated counter never repeats the pulse.
    // ------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_key
            logic [HOLD_W-1:0] hold_cnt;
            logic              pulse;

            // Hold counter and press pulse for one key
            always_ff @(posedge sclk or negedge s_rst_n) begin
                if (!s_rst_n) begin
                    hold_cnt <= '0;
                    pulse    <= 1'b0;
                end else begin
                    pulse <= ~key[gi] && (hold_cnt == HOLD_LAST);
                    if (key[gi]) begin
                        hold_cnt <= '0;
                    end else if (hold_cnt < HOLD_MAX) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
            end

            assign press[gi] = pulse;
        end
    endgenerate

    assign running = (state != MODE_OFF) && !paused;
    assign tick    = running && (step == STEP_LAST);

    // Mode / pattern state: an accepted press (lowest index wins) always
    // pre-empts the timer for that cycle, so a coincident tick is dropped.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state  <= MODE_OFF;
            led    <= 4'b0000;
            paused <= 1'b0;
            step   <= '0;
        end else if (press[0]) begin
            state  <= MODE_OFF;
            led    <= 4'b0000;
            paused <= 1'b0;
            step   <= '0;
        end else if (press[1]) begin
            state  <= MODE_BLINK;
            led    <= 4'b1111;
            paused <= 1'b0;
            step   <= '0;
        end else if (press[2]) begin
            state  <= MODE_RUN;
            led    <= 4'b0001;
            paused <= 1'b0;
            step   <= '0;
        end else if (press[3]) begin
            // Pause toggles only while a pattern exists; timer holds this cycle
            if (state != MODE_OFF) begin
                paused <= ~paused;
            end
        end else if (running) begin
            if (tick) begin
                step <= '0;
                if (state == MODE_BLINK) begin
                    led <= ~led;
                end else begin
                    led <= {led[2:0], led[3]};
                end
            end else begin
                step <= step + 1'b1;
            end
        end
    end

    assign mode = state;

endmodule
`default_nettype wire

// File: tb/tb_key_led_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_key_led_ctrl
//  Purpose  : Self-checking bench for key_led_ctrl (DELAY_10MS=4, STEP_CNT=3)
//  Revision : 1.0  initial release
// ============================================================================
module tb_key_led_ctrl;

    localparam int D = 4;
    localparam int S = 3;

    logic       sclk    = 1'b0;
    logic       s_rst_n = 1'b0;
    logic [3:0] key     = 4'b1111;
    logic [3:0] led;
    logic [1:0] mode;
    logic       paused;

    int passed = 0;
    int total  = 0;

    key_led_ctrl #(.DELAY_10MS(D), .STEP_CNT(S)) dut (
        .sclk    (sclk),
        .s_rst_n (s_rst_n),
        .key     (key),
        .led     (led),
        .mode    (mode),
        .paused  (paused)
    );

    always #5 sclk = ~sclk;

    // ------------------------------------------------------------------------
    // Behavioural model: run length of each key's low period, a registered
    // press vector, the current mode, and the number of running cycles since
    // the mode was entered. The LED pattern is derived from that count.
    // ------------------------------------------------------------------------
    int         run_len [4] = '{0, 0, 0, 0};
    logic [3:0] m_press     = 4'b0000;
    int         m_mode      = 0;
    bit         m_paused    = 1'b0;
    int         elapsed     = 0;
    logic [3:0] nxt_press;

    function automatic logic [3:0] model_led(int md, int el);
        int ph;
        ph = el / S;
        if (md == 1) return (ph % 2 == 0) ? 4'b1111 : 4'b0000;
        if (md == 2) return 4'b0001 << (ph % 4);
        return 4'b0000;
    endfunction

    always @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            for (int i = 0; i < 4; i++) run_len[i] = 0;
            m_press  = 4'b0000;
            m_mode   = 0;
            m_paused = 1'b0;
            elapsed  = 0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (key[i]) run_len[i] = 0;
                else if (run_len[i] <= D) run_len[i] = run_len[i] + 1;
                nxt_press[i] = (run_len[i] == D);
            end
            if (m_press[0])      begin m_mode = 0; m_paused = 0; elapsed = 0; end
            else if (m_press[1]) begin m_mode = 1; m_paused = 0; elapsed = 0; end
            else if (m_press[2]) begin m_mode = 2; m_paused = 0; elapsed = 0; end
            else if (m_press[3]) begin
                if (m_mode != 0) m_paused = !m_paused;
            end else if (m_mode != 0 && !m_paused) begin
                elapsed = elapsed + 1;
            end
            m_press = nxt_press;
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total = total + 1;
        if (act === exp) passed = passed + 1;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Every cycle: DUT outputs against the model, shortly after the edge
    always @(posedge sclk) begin
        #1;
        chk("model_led",    32'(led),    32'(model_led(m_mode, elapsed)));
        chk("model_mode",   32'(mode),   32'(m_mode));
        chk("model_paused", 32'(paused), 32'(m_paused));
    end

    task automatic cyc(int n);
        repeat (n) @(negedge sclk);
    endtask

    task automatic press_key(int idx, int hold);
        key[idx] = 1'b0;
        cyc(hold);
        key[idx] = 1'b1;
    endtask

    initial begin
        // Reset state
        cyc(3);
        chk("reset_led", 32'(led), 32'h0);
        chk("reset_mode", 32'(mode), 32'h0);
        chk("reset_paused", 32'(paused), 32'h0);
        s_rst_n = 1'b1;
        cyc(3);

        // Bounce rejection: 3 low cycles are too short
        press_key(1, 3);
        cyc(6);
        chk("bounce_mode", 32'(mode), 32'h0);
        chk("bounce_led", 32'(led), 32'h0);

        // RUN entry and rotation every 3 cycles
        key[2] = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            cyc(1);
            if (k == 10) key[2] = 1'b1;
            if (k == 5)  begin chk("run_mode", 32'(mode), 32'h2); chk("run_led0", 32'(led), 32'h1); end
            if (k == 8)  chk("run_led1", 32'(led), 32'h2);
            if (k == 11) chk("run_led2", 32'(led), 32'h4);
            if (k == 14) chk("run_led3", 32'(led), 32'h8);
            if (k == 17) chk("run_led4", 32'(led), 32'h1);
        end
        cyc(3);

        // BLINK, pause for 20+ cycles, resume
        press_key(1, 5);
        chk("blink_mode", 32'(mode), 32'h1);
        chk("blink_led", 32'(led), 32'hF);
        cyc(4);
        press_key(3, 5);
        chk("pause_on", 32'(paused), 32'h1);
        cyc(20);
        chk("pause_hold", 32'(paused), 32'h1);
        press_key(3, 5);
        chk("pause_off", 32'(paused), 32'h0);
        cyc(7);

        // Simultaneous key0+key1 in RUN: OFF wins, key1 lost
        press_key(2, 5);
        cyc(4);
        key = 4'b1100;
        cyc(5);
        key = 4'b1111;
        chk("prio_mode", 32'(mode), 32'h0);
        chk("prio_led", 32'(led), 32'h0);
        cyc(10);
        chk("prio_lost", 32'(mode), 32'h0);

        // key3 in OFF has no effect
        press_key(3, 5);
        chk("off_pause", 32'(paused), 32'h0);
        cyc(5);

        // Press coincident with the tick at led=0100: restart wins
        key[2] = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            cyc(1);
            if (k == 5)  key[2] = 1'b1;
            if (k == 9)  key[2] = 1'b0;
            if (k == 11) chk("coin_pre", 32'(led), 32'h4);
            if (k == 13) chk("coin_hold", 32'(led), 32'h4);
            if (k == 14) chk("coin_led", 32'(led), 32'h1);
        end
        cyc(3);

        // Asynchronous reset with key2 still held
        s_rst_n = 1'b0;
        #1;
        chk("async_led", 32'(led), 32'h0);
        chk("async_mode", 32'(mode), 32'h0);
        cyc(1);
        s_rst_n = 1'b1;
        cyc(4);
        chk("rel_wait", 32'(mode), 32'h0);
        cyc(1);
        chk("rel_press", 32'(mode), 32'h2);
        key = 4'b1111;
        cyc(3);

        // Randomised key activity with occasional reset pulses
        for (int n = 0; n < 4000; n++) begin
            cyc(1);
            if (!s_rst_n) s_rst_n = 1'b1;
            else if ($urandom_range(0, 799) == 0) s_rst_n = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 5) == 0) key[i] = ~key[i];
            end
        end
        key = 4'b1111;
        cyc(5);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
